button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the number of consecutive enabled cycles a synchronized input must differ from its debounced level before the level is accepted (10 ms at 25 MHz); legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 18, SHALL set the debounce counter width.
REQ-003 Parameter ACTIVE_LOW, default 0, SHALL invert all three raw inputs at the synchronizer input when 1.
REQ-004 Port clk, input, 1 bit: the single clock, also the breakout pixel clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port en, input, 1 bit: when 1, debounce counting and pulse generation are enabled.
REQ-007 Ports raw_left, raw_right, raw_select, inputs, 1 bit each: asynchronous, bouncing pad inputs.
REQ-008 Ports btn_left, btn_right, btn_select, outputs, 1 bit each: debounced levels that drive the breakout button inputs.
REQ-009 Ports left_press, right_press, select_press, outputs, 1 bit each: single-cycle pulses on a debounced 0->1 transition.
REQ-010 Port busy, output, 1 bit: high while any channel counter is non-zero.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer, after optional inversion, before any other use.
REQ-012 Each channel SHALL hold a debounced level S and a counter C of CNT_W bits.
REQ-013 If the synchronized value equals S, C SHALL be cleared to 0 on the next edge.
REQ-014 If the synchronized value differs from S and en=1 and C<DEBOUNCE_CYCLES-1, C SHALL increment.
REQ-015 If the synchronized value differs from S and en=1 and C=DEBOUNCE_CYCLES-1, S SHALL take the synchronized value and C SHALL clear, on the same edge.
REQ-016 A mismatch shorter than DEBOUNCE_CYCLES enabled cycles SHALL leave S unchanged, and the counter restart SHALL be from 0.
REQ-017 Latency: for a raw input first sampled at edge 1 and held, S SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-018 When en=0, C and S SHALL hold, all press pulses SHALL be 0, and synchronizers SHALL keep sampling.
REQ-019 An x_press output SHALL be 1 for exactly the one cycle following the edge where that channel's S goes 0->1; a 1->0 transition SHALL give no pulse.
REQ-020 btn_select SHALL equal S_select.
REQ-021 btn_left SHALL equal S_left AND NOT S_right, and btn_right SHALL equal S_right AND NOT S_left, so both held stops the paddle.
REQ-022 left_press and right_press SHALL follow the raw S transitions, independent of the mutual-exclusion rule in REQ-021.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be processed in the same cycle.
REQ-024 Counters SHALL never wrap: C stays at most DEBOUNCE_CYCLES-1 under all input sequences.
REQ-025 busy SHALL be combinational: the OR of (C!=0) over all channels.

Reset
REQ-026 With rst=1 at a rising edge, all of the following SHALL be cleared on that edge: every S, every C, every press output, and every output level.
REQ-027 During reset, synchronizer flops SHALL load the idle level (0 after inversion), so a button held through reset is seen as a fresh press once rst is released.
REQ-028 Reset asserted mid-count SHALL discard the count; counting SHALL restart from 0 after rst is released.
REQ-029 Outputs in the first cycle after reset SHALL be btn_*=0, *_press=0 and busy=0.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0)
REQ-030 raw_left 0->1 sampled at edge 1 and held -> btn_left=1 after edge 6; left_press=1 for exactly that one cycle; busy high during the count.
REQ-031 raw_select high for 3 cycles then low -> btn_select stays 0, no select_press, C returns to 0.
REQ-032 raw_left and raw_right both held high -> S_left=S_right=1 after edge 6 while btn_left=btn_right=0; left_press and right_press each pulse once.
REQ-033 en=0 after 2 counted cycles, then en=1 with raw_right still high -> btn_right rises 2 enabled cycles later; no pulse while en=0.
REQ-034 raw_select held high through rst, then rst released at edge N -> btn_select=1 and select_press pulses after edge N+6.
REQ-035 ACTIVE_LOW=1, raw inputs idle at 1 through reset -> all outputs remain 0 after reset, with no spurious pulses.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw pad inputs and enable in,
// debounced levels, press pulses and busy out.
interface button_conditioner_if;
  logic en;
  logic raw_left;
  logic raw_right;
  logic raw_select;
  logic btn_left;
  logic btn_right;
  logic btn_select;
  logic left_press;
  logic right_press;
  logic select_press;
  logic busy;

  modport master (
    output en, raw_left, raw_right, raw_select,
    input  btn_left, btn_right, btn_select,
    input  left_press, right_press, select_press, busy
  );

  modport slave (
    input  en, raw_left, raw_right, raw_select,
    output btn_left, btn_right, btn_select,
    output left_press, right_press, select_press, busy
  );
endinterface

// File: rtl/button_conditioner.sv
// Three-channel button conditioner: 2-flop synchronizers, per-channel
// counter debounce, rising-edge press pulses and left/right exclusion.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  button_conditioner_if.slave  bus
);

  localparam int unsigned      NCH      = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order in all vectors: 0 = left, 1 = right, 2 = select.
  logic [NCH-1:0]   raw_vec;
  logic [NCH-1:0]   sync_meta;
  logic [NCH-1:0]   sync_q;
  logic [NCH-1:0]   level_q;
  logic [NCH-1:0]   level_d;
  logic [NCH-1:0]   rise_d;
  logic [NCH-1:0]   press_q;
  logic [NCH-1:0]   cnt_nz;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  always_comb begin
    raw_vec = {bus.raw_select, bus.raw_right, bus.raw_left} ^ {NCH{ACTIVE_LOW}};
  end

  // Reset loads the idle level so a button held through reset reads as a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw_vec;
      sync_q    <= sync_meta;
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.en) begin
        if (sync_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= CNT_LAST) begin
          level_d[i] = sync_q[i];
          rise_d[i]  = sync_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      press_q <= rise_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_nz[i] = (cnt_q[i] != '0);
    end
  end

  // Both directions held cancels paddle motion; press pulses ignore this.
  assign bus.btn_left     = level_q[0] & ~level_q[1];
  assign bus.btn_right    = level_q[1] & ~level_q[0];
  assign bus.btn_select   = level_q[2];
  assign bus.left_press   = press_q[0] & bus.en;
  assign bus.right_press  = press_q[1] & bus.en;
  assign bus.select_press = press_q[2] & bus.en;
  assign bus.busy         = |cnt_nz;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4; a second instance
// uses ACTIVE_LOW=1 with its raw inputs idling high.
module tb_button_conditioner;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [6:0] exp_q [$];
  logic [6:0] got;
  logic [6:0] want;

  button_conditioner_if bus1 ();
  button_conditioner_if bus2 ();

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, select_press, right_press, left_press, btn_select, btn_right, btn_left}
  function automatic logic [6:0] obs1();
    return {bus1.busy, bus1.select_press, bus1.right_press, bus1.left_press,
            bus1.btn_select, bus1.btn_right, bus1.btn_left};
  endfunction

  function automatic logic [6:0] obs2();
    return {bus2.busy, bus2.select_press, bus2.right_press, bus2.left_press,
            bus2.btn_select, bus2.btn_right, bus2.btn_left};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(7'b0);
      exp_q.push_back(7'b0);
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset k=%0d got %b want %b", k, got, want);
      end
      got = obs2(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_al k=%0d got %b want %b", k, got, want);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_active_low_idle();
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(7'b0);
      @(posedge clk); #1;
      got = obs2(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL active_low_idle k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_press_release();
    bus1.raw_left = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 1'b0, 1'b0, (k == 6), 1'b0, 1'b0, (k >= 6)});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_press k=%0d got %b want %b", k, got, want);
      end
    end
    bus1.raw_left = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 3'b000, 1'b0, 1'b0, (k < 6)});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_release k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_glitch();
    bus1.raw_select = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 6'b000000});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL select_glitch k=%0d got %b want %b", k, got, want);
      end
      if (k == 3) bus1.raw_select = 1'b0;
    end
  endtask

  task automatic test_both_held();
    bus1.raw_left  = 1'b1;
    bus1.raw_right = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 1'b0, (k == 6), (k == 6), 3'b000});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL both_held k=%0d got %b want %b", k, got, want);
      end
    end
    bus1.raw_right = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 3'b000, 1'b0, 1'b0, (k >= 6)});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL right_drop k=%0d got %b want %b", k, got, want);
      end
    end
    bus1.raw_left = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 3'b000, 1'b0, 1'b0, (k < 6)});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_drop k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_enable_pause();
    bus1.raw_right = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back({(k >= 3 && k <= 10), 1'b0, (k == 11), 1'b0, 1'b0, (k >= 11), 1'b0});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL enable_pause k=%0d got %b want %b", k, got, want);
      end
      if (k == 4) bus1.en = 1'b0;
      if (k == 9) bus1.en = 1'b1;
    end
    bus1.raw_right = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 3'b000, 1'b0, (k < 6), 1'b0});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL right_release k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_held_press();
    bus1.raw_select = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 4)
        exp_q.push_back({(k >= 3), 6'b000000});
      else if (k <= 7)
        exp_q.push_back(7'b0);
      else
        exp_q.push_back({(k - 7 >= 3 && k - 7 <= 5), (k - 7 == 6), 2'b00, (k - 7 >= 6), 2'b00});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_held k=%0d got %b want %b", k, got, want);
      end
      if (k == 4) rst = 1'b1;
      if (k == 7) rst = 1'b0;
    end
    bus1.raw_select = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({(k >= 3 && k <= 5), 3'b000, (k < 6), 2'b00});
      @(posedge clk); #1;
      got = obs1(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL select_release k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus1.en         = 1'b1;
    bus1.raw_left   = 1'b0;
    bus1.raw_right  = 1'b0;
    bus1.raw_select = 1'b0;
    bus2.en         = 1'b1;
    bus2.raw_left   = 1'b1;
    bus2.raw_right  = 1'b1;
    bus2.raw_select = 1'b1;
    #1;
    test_reset();
    test_active_low_idle();
    test_press_release();
    test_glitch();
    test_both_held();
    test_enable_pause();
    test_reset_held_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
